// File: rtl/fetch_unit_pipeline.sv
// Instruction fetch stage: PC generation, credit-limited imem requests, prefetch FIFO
// and the IF/ID register feeding decode. Redirects drain stale responses via a discard count.
module fetch_unit_pipeline #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2,
  parameter logic [31:0] NOP      = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [31:0]      pcf_reg;
  logic [CNT_W-1:0] outstanding_reg;
  logic [CNT_W-1:0] discard_reg;
  logic [CNT_W-1:0] count_reg;
  logic [PTR_W-1:0] fifo_rd_reg;
  logic [PTR_W-1:0] fifo_wr_reg;
  logic [PTR_W-1:0] pcq_rd_reg;
  logic [PTR_W-1:0] pcq_wr_reg;

  logic [31:0] fifo_instr [DEPTH];
  logic [31:0] fifo_pc    [DEPTH];
  logic [31:0] pcq_mem    [DEPTH];

  logic [31:0] instr_d_reg;
  logic [31:0] pc_d_reg;
  logic [31:0] pc_plus4_d_reg;
  logic        valid_d_reg;

  logic [CNT_W:0] in_use;
  logic           credit_ok;
  logic           handshake;
  logic           accept;
  logic           load_ifid;
  logic           fifo_empty;
  logic           pop;
  logic           bypass;
  logic           push;
  logic [31:0]    resp_pc;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Credits cover both in-flight requests and buffered words, so the FIFO can never overflow.
  assign in_use    = {1'b0, outstanding_reg} + {1'b0, count_reg};
  assign credit_ok = in_use < {1'b0, DEPTH_C};
  assign imem_req  = !reset && !PCSrcE && credit_ok;
  assign imem_addr = pcf_reg;
  assign handshake = imem_req && imem_ready;

  // A response is kept only when it is not stale and no redirect is happening right now.
  assign accept     = imem_rvalid && !PCSrcE && (discard_reg == '0);
  assign load_ifid  = !FlushD && !StallD;
  assign fifo_empty = (count_reg == '0);
  assign pop        = load_ifid && !fifo_empty;
  assign bypass     = load_ifid && fifo_empty && accept;
  assign push       = accept && !bypass;
  assign resp_pc    = pcq_mem[pcq_rd_reg];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pcf_reg         <= RESET_PC;
      outstanding_reg <= '0;
      discard_reg     <= '0;
      count_reg       <= '0;
      fifo_rd_reg     <= '0;
      fifo_wr_reg     <= '0;
      pcq_rd_reg      <= '0;
      pcq_wr_reg      <= '0;
    end else begin
      outstanding_reg <= outstanding_reg + CNT_W'(handshake) - CNT_W'(imem_rvalid);
      if (PCSrcE) begin
        pcf_reg     <= PCTargetE;
        discard_reg <= outstanding_reg - CNT_W'(imem_rvalid);
        count_reg   <= '0;
        fifo_rd_reg <= '0;
        fifo_wr_reg <= '0;
        pcq_rd_reg  <= '0;
        pcq_wr_reg  <= '0;
      end else begin
        if (handshake) begin
          pcf_reg    <= pcf_reg + 32'd4;
          pcq_wr_reg <= ptr_inc(pcq_wr_reg);
        end
        if (imem_rvalid && (discard_reg != '0)) discard_reg <= discard_reg - 1'b1;
        if (accept) pcq_rd_reg <= ptr_inc(pcq_rd_reg);
        if (push) fifo_wr_reg <= ptr_inc(fifo_wr_reg);
        if (pop) fifo_rd_reg <= ptr_inc(fifo_rd_reg);
        count_reg <= count_reg + CNT_W'(push) - CNT_W'(pop);
      end
    end
  end

  // Storage arrays carry no reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_instr[fifo_wr_reg] <= imem_rdata;
      fifo_pc[fifo_wr_reg]    <= resp_pc;
    end
    if (handshake) pcq_mem[pcq_wr_reg] <= pcf_reg;
    if (!reset) assert (!(push && (count_reg == DEPTH_C)));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_d_reg    <= NOP;
      pc_d_reg       <= '0;
      pc_plus4_d_reg <= '0;
      valid_d_reg    <= 1'b0;
    end else if (FlushD) begin
      instr_d_reg    <= NOP;
      pc_d_reg       <= '0;
      pc_plus4_d_reg <= '0;
      valid_d_reg    <= 1'b0;
    end else if (!StallD) begin
      if (pop) begin
        instr_d_reg    <= fifo_instr[fifo_rd_reg];
        pc_d_reg       <= fifo_pc[fifo_rd_reg];
        pc_plus4_d_reg <= fifo_pc[fifo_rd_reg] + 32'd4;
        valid_d_reg    <= 1'b1;
      end else if (bypass) begin
        instr_d_reg    <= imem_rdata;
        pc_d_reg       <= resp_pc;
        pc_plus4_d_reg <= resp_pc + 32'd4;
        valid_d_reg    <= 1'b1;
      end else begin
        instr_d_reg    <= NOP;
        pc_d_reg       <= '0;
        pc_plus4_d_reg <= '0;
        valid_d_reg    <= 1'b0;
      end
    end
  end

  assign InstrD   = instr_d_reg;
  assign PCD      = pc_d_reg;
  assign PCPlus4D = pc_plus4_d_reg;
  assign ValidD   = valid_d_reg;

endmodule

// File: tb/tb_fetch_unit_pipeline.sv
// Bench for fetch_unit_pipeline: in-order memory model with programmable latency,
// directed scenarios, then a randomized run checked against a program-order stream model.
module tb_fetch_unit_pipeline;

  localparam int          DEPTH    = 2;
  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk;
  logic        reset;
  logic        StallD;
  logic        FlushD;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] InstrD;
  logic [31:0] PCD;
  logic [31:0] PCPlus4D;
  logic        ValidD;

  fetch_unit_pipeline #(.RESET_PC(RESET_PC), .DEPTH(DEPTH), .NOP(NOP)) dut (
    .clk(clk), .reset(reset), .StallD(StallD), .FlushD(FlushD), .PCSrcE(PCSrcE),
    .PCTargetE(PCTargetE), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } req_t;

  req_t        mq[$];
  int          cyc = 0;
  int          lat_max = 1;
  logic        resp_en = 1'b1;
  int          tests = 0;
  int          fails = 0;
  logic        last_req, last_ready;
  logic [31:0] last_addr;
  logic [31:0] pre_instr, pre_pc, pre_pc4;
  logic        pre_valid;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    if (a == 32'h4) return 32'h00A0_0113;
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: present the head response if due, sample pre-edge state, advance the memory model.
  task automatic step();
    logic hs, rv;
    if (resp_en && mq.size() > 0 && mq[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(mq[0].addr);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
    #3;
    hs = imem_req & imem_ready;
    rv = imem_rvalid;
    last_req = imem_req; last_addr = imem_addr; last_ready = imem_ready;
    pre_instr = InstrD; pre_pc = PCD; pre_pc4 = PCPlus4D; pre_valid = ValidD;
    @(posedge clk);
    #1;
    cyc++;
    if (rv) void'(mq.pop_front());
    if (hs) mq.push_back('{addr: last_addr, due: cyc + int'($urandom_range(1, lat_max)) - 1});
    chk("credit_cap", 32'(mq.size() <= DEPTH), 32'd1);
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    do begin
      step();
      n++;
    end while (!ValidD && n < 12);
    chk(tag, 32'(ValidD), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] hold_pc, hold_instr, held, exp_pc;
    reset = 1'b1; StallD = 0; FlushD = 0; PCSrcE = 0; PCTargetE = '0;
    imem_ready = 1'b1; imem_rvalid = 1'b0; imem_rdata = '0;
    @(posedge clk);
    #1;
    chk("rst_instr", InstrD, NOP);
    chk("rst_pcd", PCD, 32'h0);
    chk("rst_pc4", PCPlus4D, 32'h0);
    chk("rst_valid", 32'(ValidD), 32'd0);
    chk("rst_req", 32'(imem_req), 32'd0);
    step();
    reset = 1'b0;

    // 1: basic streaming, 1-cycle latency
    step();
    chk("t1_req0", 32'(last_req), 32'd1);
    chk("t1_addr0", last_addr, RESET_PC);
    chk("t1_valid0", 32'(ValidD), 32'd0);
    step();
    chk("t1_addr1", last_addr, 32'h4);
    chk("t1_instr0", InstrD, 32'h0050_0093);
    chk("t1_pcd0", PCD, 32'h0);
    chk("t1_pc4_0", PCPlus4D, 32'h4);
    chk("t1_valid1", 32'(ValidD), 32'd1);
    step();
    chk("t1_instr1", InstrD, 32'h00A0_0113);
    chk("t1_pcd1", PCD, 32'h4);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t1_sus_valid", 32'(ValidD), 32'd1);
      chk("t1_sus_pcd", PCD, 32'(8 + 4 * k));
      chk("t1_sus_instr", InstrD, mem_word(32'(8 + 4 * k)));
    end

    // 2: stall for three cycles
    hold_pc = PCD; hold_instr = InstrD;
    StallD = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t2_hold_pc", PCD, hold_pc);
      chk("t2_hold_instr", InstrD, hold_instr);
      if (k > 0) chk("t2_req_drop", 32'(last_req), 32'd0);
    end
    StallD = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      step();
      chk("t2_rel_valid", 32'(ValidD), 32'd1);
      chk("t2_rel_pcd", PCD, hold_pc + 32'(4 * k));
      chk("t2_rel_instr", InstrD, mem_word(hold_pc + 32'(4 * k)));
    end

    // 3: redirect with two requests outstanding
    resp_en = 1'b0;
    step();
    step();
    chk("t3_outstanding", 32'(mq.size()), 32'd2);
    PCSrcE = 1'b1; FlushD = 1'b1; PCTargetE = 32'h40;
    step();
    chk("t3_valid", 32'(ValidD), 32'd0);
    chk("t3_instr", InstrD, NOP);
    chk("t3_noreq", 32'(last_req), 32'd0);
    PCSrcE = 1'b0; FlushD = 1'b0; resp_en = 1'b1;
    wait_valid("t3_wait");
    chk("t3_pcd", PCD, 32'h40);
    chk("t3_instr40", InstrD, mem_word(32'h40));

    // 4: memory not ready for five cycles
    imem_ready = 1'b0;
    step();
    held = last_addr;
    chk("t4_addr_next", held, PCD + 32'd4);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("t4_req", 32'(last_req), 32'd1);
      chk("t4_addr", last_addr, held);
      chk("t4_valid", 32'(ValidD), 32'd0);
    end
    imem_ready = 1'b1;
    wait_valid("t4_wait");
    chk("t4_pcd", PCD, held);

    // 6: wrap at the top of the address space
    PCSrcE = 1'b1; FlushD = 1'b1; PCTargetE = 32'hFFFF_FFFC;
    step();
    PCSrcE = 1'b0; FlushD = 1'b0;
    wait_valid("t6_wait0");
    chk("t6_pcd0", PCD, 32'hFFFF_FFFC);
    chk("t6_pc4_0", PCPlus4D, 32'h0);
    chk("t6_instr0", InstrD, mem_word(32'hFFFF_FFFC));
    wait_valid("t6_wait1");
    chk("t6_pcd1", PCD, 32'h0);
    chk("t6_instr1", InstrD, 32'h0050_0093);

    // 5: asynchronous reset mid-cycle with the FIFO full
    StallD = 1'b1;
    step(); step(); step();
    chk("t5_pre_valid", 32'(ValidD), 32'd1);
    chk("t5_pre_noreq", 32'(last_req), 32'd0);
    #1;
    reset = 1'b1;
    #1;
    chk("t5_instr", InstrD, NOP);
    chk("t5_valid", 32'(ValidD), 32'd0);
    chk("t5_pcd", PCD, 32'h0);
    chk("t5_pc4", PCPlus4D, 32'h0);
    chk("t5_req", 32'(imem_req), 32'd0);
    mq.delete();
    StallD = 1'b0;
    step();
    reset = 1'b0;
    step();
    chk("t5_req_after", 32'(last_req), 32'd1);
    chk("t5_addr_after", last_addr, RESET_PC);
    wait_valid("t5_wait");
    chk("t5_first_pcd", PCD, RESET_PC);
    chk("t5_first_instr", InstrD, 32'h0050_0093);

    // Randomized run against a program-order stream model
    lat_max = 3;
    PCSrcE = 1'b1; FlushD = 1'b1; PCTargetE = 32'h100;
    step();
    exp_pc = 32'h100;
    for (int i = 0; i < 1500; i++) begin
      logic stall, flush, redir, p_req, p_ready;
      logic [31:0] tgt, p_addr;
      redir = ($urandom_range(0, 19) == 0);
      flush = redir || ($urandom_range(0, 29) == 0);
      stall = ($urandom_range(0, 4) == 0);
      tgt   = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'h0000_FFFC);
      StallD = stall; FlushD = flush; PCSrcE = redir; PCTargetE = tgt;
      imem_ready = ($urandom_range(0, 9) < 7);
      p_req = last_req; p_ready = last_ready; p_addr = last_addr;
      step();
      if (p_req && !p_ready && !redir) begin
        chk("rnd_req_held", 32'(last_req), 32'd1);
        chk("rnd_addr_held", last_addr, p_addr);
      end
      if (flush) begin
        chk("rnd_flush_valid", 32'(ValidD), 32'd0);
        chk("rnd_flush_instr", InstrD, NOP);
      end else if (stall) begin
        chk("rnd_stall_instr", InstrD, pre_instr);
        chk("rnd_stall_pc", PCD, pre_pc);
        chk("rnd_stall_pc4", PCPlus4D, pre_pc4);
        chk("rnd_stall_valid", 32'(ValidD), 32'(pre_valid));
      end else if (ValidD) begin
        chk("rnd_pcd", PCD, exp_pc);
        chk("rnd_instr", InstrD, mem_word(exp_pc));
        chk("rnd_pc4", PCPlus4D, exp_pc + 32'd4);
        exp_pc = exp_pc + 32'd4;
      end else begin
        chk("rnd_bubble", InstrD, NOP);
      end
      if (redir) exp_pc = tgt;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fetch_unit_pipeline.md
Name: fetch_unit_pipeline

Overview:
Instruction fetch stage for the 5-stage RV32 pipeline. It is the producer side of the decode interface: it generates PCs, issues requests to instruction memory over a valid/ready handshake, and buffers returned words in a small prefetch FIFO. It presents one instruction per cycle in the IF/ID register (InstrD, PCD, PCPlus4D), from which the decode-stage control unit takes op/funct3/funct7b5. It honours decode stall and flush, and redirects from execute on branch/jal.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset
DEPTH, 2, prefetch FIFO entries; also the cap on requests outstanding plus entries buffered
NOP, 32'h0000_0013, bubble word (addi x0,x0,0) driven on InstrD when no valid instruction is present

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
StallD  in  1  hold IF/ID register contents
FlushD  in  1  replace IF/ID register with a bubble next edge
PCSrcE  in  1  redirect request from execute (taken branch or jal)
PCTargetE  in  32  redirect target address
imem_req  out  1  request valid to instruction memory
imem_addr  out  32  request address (= PCF)
imem_ready  in  1  memory accepts request this cycle
imem_rvalid  in  1  response valid; responses return in request order
imem_rdata  in  32  response instruction word
InstrD  out  32  IF/ID instruction
PCD  out  32  IF/ID PC
PCPlus4D  out  32  IF/ID PC+4
ValidD  out  1  IF/ID holds a real instruction

Behaviour:
- Reset (asynchronous, any cycle, including with requests in flight): PCF=RESET_PC; FIFO empty; outstanding=0; discard=0; InstrD=NOP; PCD=0; PCPlus4D=0; ValidD=0. imem_req=0 while reset is high.
- Request issue: imem_req = !reset & !PCSrcE & (outstanding + count < DEPTH). A handshake (imem_req & imem_ready) increments outstanding and advances PCF to PCF+4. imem_addr=PCF is stable while imem_req is high and unaccepted.
- Each FIFO entry holds {instr, pc}; pc is captured per request in a DEPTH-deep in-order PC queue alongside outstanding.
- Response: on imem_rvalid, outstanding decrements. If discard>0, the word is dropped and discard decrements. Otherwise the word is pushed with its PC. The credit rule guarantees the FIFO never overflows; a push when full is an assertion failure.
- IF/ID update priority, per edge: FlushD, then StallD, then normal.
  - FlushD: InstrD=NOP, PCD=0, PCPlus4D=0, ValidD=0. No FIFO pop.
  - StallD (and not FlushD): hold all IF/ID outputs. No pop.
  - Normal, FIFO non-empty: load the head entry, PCPlus4D=pc+4, ValidD=1, pop.
  - Normal, FIFO empty: load a bubble (as for flush).
- Bypass: a response arriving when the FIFO is empty and IF/ID is loading is written straight into IF/ID the same edge. Minimum latency is 1 cycle from rvalid to InstrD.
- Redirect (PCSrcE=1): at the edge, PCF=PCTargetE; FIFO cleared; discard = outstanding minus any response consumed this cycle; PC queue cleared; no request issued that cycle. PCSrcE does not itself touch IF/ID; the hazard unit asserts FlushD with it.
- Simultaneous events:
  - Redirect and rvalid in the same cycle: the response is dropped.
  - Redirect and FIFO pop in the same cycle: the popped entry still enters IF/ID unless FlushD is also high.
  - A second redirect while discard>0: discard is recomputed from the current outstanding count.
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC+4 wraps to 0. Bits [1:0] of PCTargetE are passed through unchecked.
- States, per-cycle counters: FETCH (credits available), WAIT (credits exhausted), DRAIN (discard>0). DRAIN may overlap request issue to the new PC.

Test Plan:
1. Reset release, imem_ready=1, fixed 1-cycle response latency, words 0x00500093, 0x00A00113 → requests at 0x0, 0x4; InstrD shows 0x00500093 with PCD=0, then 0x00A00113 with PCD=4, ValidD=1; one instruction per cycle sustained.
2. StallD high for 3 cycles mid-stream → InstrD/PCD frozen; imem_req drops once outstanding+count=2; no word lost or duplicated after release.
3. PCSrcE=1 and FlushD=1, PCTargetE=0x40, with 2 requests outstanding → next edge ValidD=0 and InstrD=0x00000013; both late responses discarded; next ValidD=1 has PCD=0x40.
4. imem_ready held low 5 cycles → imem_req stays 1 with imem_addr constant; ValidD=0 and bubbles flow to decode.
5. Assert reset asynchronously mid-cycle with FIFO full → outputs reset immediately, before the next edge; after release the first request is to RESET_PC.
6. PCTargetE=0xFFFFFFFC → fetches 0xFFFFFFFC then 0x00000000; PCPlus4D=0 for the first instruction.
